// File: rtl/usb_hc_pio_responder.sv
// Device-side responder for a 16-bit ISP1362-style PIO bus: a command port selects a
// 32-bit register, the data port moves it as two 16-bit words (low first), plus a level IRQ.
module usb_hc_pio_responder #(
  parameter int          NUM_REGS = 8,
  parameter logic [31:0] CHIP_ID  = 32'h0036_1362
) (
  input  logic        clk_bus,
  input  logic        rst_n,
  input  logic        dev_a0,
  input  logic        dev_cs_n,
  input  logic        dev_rd_n,
  input  logic        dev_we_n,
  input  logic [15:0] dev_data_i,
  output logic [15:0] dev_data_o,
  output logic        dev_data_t,
  output logic        dev_int,
  input  logic [15:0] loc_irq_set,
  output logic        loc_wr_pulse,
  output logic [6:0]  loc_wr_index
);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_WR   = 2'd1,
    ST_RD   = 2'd2
  } state_e;

  localparam logic [7:0] NUM_REGS_W = 8'(NUM_REGS);

  logic        a0_m_q, cs_m_q, rd_m_q, we_m_q;
  logic        a0_s, cs_s, rd_s, we_s;
  logic [15:0] data_m_q, data_s;

  state_e      state_q;
  logic        cmd_valid_q, cmd_dir_q, word_ptr_q;
  logic [6:0]  cmd_idx_q;
  logic [15:0] hold_lo_q, hold_hi_q, rd_hi_q;
  logic        wr_a0_q, rd_a0_q;
  logic [15:0] wr_data_q;
  logic [15:0] status_q, enable_q;
  logic [31:0] scratch_q [NUM_REGS];
  logic [15:0] data_o_q;
  logic        data_t_q, int_q, wr_pulse_q;
  logic [6:0]  wr_index_q;

  logic        mapped_s, rd_ok_s, wr_exit_s, wr_commit_s;
  logic [31:0] reg_word_s;
  logic [15:0] rd_word_s, clr_s;

  assign dev_data_o   = data_o_q;
  assign dev_data_t   = data_t_q;
  assign dev_int      = int_q;
  assign loc_wr_pulse = wr_pulse_q;
  assign loc_wr_index = wr_index_q;

  // Two-flop synchronisers for the asynchronous master-side pins
  always_ff @(posedge clk_bus) begin
    if (!rst_n) begin
      a0_m_q   <= 1'b0;
      cs_m_q   <= 1'b1;
      rd_m_q   <= 1'b1;
      we_m_q   <= 1'b1;
      data_m_q <= 16'h0000;
      a0_s     <= 1'b0;
      cs_s     <= 1'b1;
      rd_s     <= 1'b1;
      we_s     <= 1'b1;
      data_s   <= 16'h0000;
    end else begin
      a0_m_q   <= dev_a0;
      cs_m_q   <= dev_cs_n;
      rd_m_q   <= dev_rd_n;
      we_m_q   <= dev_we_n;
      data_m_q <= dev_data_i;
      a0_s     <= a0_m_q;
      cs_s     <= cs_m_q;
      rd_s     <= rd_m_q;
      we_s     <= we_m_q;
      data_s   <= data_m_q;
    end
  end

  // Register-file view of the currently selected index
  always_comb begin
    reg_word_s = 32'h0000_0000;
    case (cmd_idx_q)
      7'd0:    reg_word_s = CHIP_ID;
      7'd1:    reg_word_s = {16'h0000, status_q};
      7'd2:    reg_word_s = {16'h0000, enable_q};
      default: begin
        for (int i = 3; i < NUM_REGS; i++) begin
          reg_word_s = (cmd_idx_q == 7'(i)) ? scratch_q[i] : reg_word_s;
        end
      end
    endcase
  end

  // Access qualification, read word selection and W1C clear vector
  always_comb begin
    mapped_s    = cmd_valid_q && ({1'b0, cmd_idx_q} < NUM_REGS_W);
    rd_ok_s     = mapped_s && !cmd_dir_q;
    wr_exit_s   = (state_q == ST_WR) && (we_s || cs_s);
    wr_commit_s = wr_exit_s && !wr_a0_q && word_ptr_q && mapped_s && cmd_dir_q &&
                  (cmd_idx_q != 7'd0);
    clr_s       = (wr_commit_s && (cmd_idx_q == 7'd1)) ? hold_lo_q : 16'h0000;
    if (a0_s) begin
      rd_word_s = {8'h00, cmd_dir_q, cmd_idx_q};
    end else if (!rd_ok_s) begin
      rd_word_s = 16'hFFFF;
    end else if (!word_ptr_q) begin
      rd_word_s = reg_word_s[15:0];
    end else begin
      rd_word_s = hold_hi_q;
    end
  end

  // Access FSM; writes and read side effects commit on the exit cycle
  always_ff @(posedge clk_bus) begin
    if (!rst_n) begin
      state_q     <= ST_IDLE;
      cmd_valid_q <= 1'b0;
      cmd_dir_q   <= 1'b0;
      cmd_idx_q   <= 7'd0;
      word_ptr_q  <= 1'b0;
      hold_lo_q   <= 16'h0000;
      hold_hi_q   <= 16'h0000;
      rd_hi_q     <= 16'h0000;
      wr_a0_q     <= 1'b0;
      rd_a0_q     <= 1'b0;
      wr_data_q   <= 16'h0000;
      status_q    <= 16'h0000;
      enable_q    <= 16'h0000;
      for (int i = 0; i < NUM_REGS; i++) begin
        scratch_q[i] <= 32'h0000_0000;
      end
      data_o_q    <= 16'h0000;
      data_t_q    <= 1'b1;
      int_q       <= 1'b0;
      wr_pulse_q  <= 1'b0;
      wr_index_q  <= 7'd0;
    end else begin
      wr_pulse_q <= 1'b0;
      // Set beats clear: the local set is OR'ed in after the W1C mask
      status_q   <= (status_q & ~clr_s) | loc_irq_set;
      int_q      <= |(status_q & enable_q);
      case (state_q)
        ST_IDLE: begin
          if (!cs_s && !we_s) begin
            state_q   <= ST_WR;
            wr_a0_q   <= a0_s;
            wr_data_q <= data_s;
          end else if (!cs_s && !rd_s) begin
            state_q  <= ST_RD;
            rd_a0_q  <= a0_s;
            data_o_q <= rd_word_s;
            data_t_q <= 1'b0;
            rd_hi_q  <= reg_word_s[31:16];
          end else begin
            state_q <= ST_IDLE;
          end
        end
        ST_WR: begin
          if (we_s || cs_s) begin
            state_q <= ST_IDLE;
            if (wr_a0_q) begin
              cmd_valid_q <= 1'b1;
              cmd_idx_q   <= wr_data_q[6:0];
              cmd_dir_q   <= wr_data_q[7];
              word_ptr_q  <= 1'b0;
            end else if (cmd_valid_q) begin
              word_ptr_q <= ~word_ptr_q;
              if (!word_ptr_q) begin
                hold_lo_q <= wr_data_q;
              end else if (wr_commit_s) begin
                wr_pulse_q <= 1'b1;
                wr_index_q <= cmd_idx_q;
                if (cmd_idx_q == 7'd2) begin
                  enable_q <= hold_lo_q;
                end
                for (int i = 3; i < NUM_REGS; i++) begin
                  if (cmd_idx_q == 7'(i)) begin
                    scratch_q[i] <= {wr_data_q, hold_lo_q};
                  end
                end
              end
            end
          end else begin
            wr_a0_q   <= a0_s;
            wr_data_q <= data_s;
          end
        end
        ST_RD: begin
          if (rd_s || cs_s) begin
            state_q  <= ST_IDLE;
            data_t_q <= 1'b1;
            if (!rd_a0_q && cmd_valid_q) begin
              word_ptr_q <= ~word_ptr_q;
              if (!word_ptr_q && rd_ok_s) begin
                hold_hi_q <= rd_hi_q;
              end
            end
          end
        end
        default: state_q <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_usb_hc_pio_responder.sv
// Directed bench for usb_hc_pio_responder: drives PIO command/data cycles and checks
// read data, tristate timing, write pulses and the interrupt path.
module tb_usb_hc_pio_responder;

  logic        clk_bus = 1'b0;
  logic        rst_n;
  logic        dev_a0, dev_cs_n, dev_rd_n, dev_we_n;
  logic [15:0] dev_data_i;
  logic [15:0] dev_data_o;
  logic        dev_data_t, dev_int;
  logic [15:0] loc_irq_set;
  logic        loc_wr_pulse;
  logic [6:0]  loc_wr_index;

  int n_checks = 0;
  int n_pass   = 0;
  int pulse_cnt = 0;
  logic [6:0] pulse_idx = 7'd0;
  logic [15:0] rdat;
  int p0;

  usb_hc_pio_responder #(.NUM_REGS(4), .CHIP_ID(32'h0036_1362)) dut (
    .clk_bus      (clk_bus),
    .rst_n        (rst_n),
    .dev_a0       (dev_a0),
    .dev_cs_n     (dev_cs_n),
    .dev_rd_n     (dev_rd_n),
    .dev_we_n     (dev_we_n),
    .dev_data_i   (dev_data_i),
    .dev_data_o   (dev_data_o),
    .dev_data_t   (dev_data_t),
    .dev_int      (dev_int),
    .loc_irq_set  (loc_irq_set),
    .loc_wr_pulse (loc_wr_pulse),
    .loc_wr_index (loc_wr_index)
  );

  always #5 clk_bus = ~clk_bus;

  // Tally write pulses seen by the local side
  always @(negedge clk_bus) begin
    if (loc_wr_pulse) begin
      pulse_cnt = pulse_cnt + 1;
      pulse_idx = loc_wr_index;
    end
  end

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks = n_checks + 1;
    if (got === exp) begin
      n_pass = n_pass + 1;
    end else begin
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic bus_write(input logic a0, input logic [15:0] d, input logic irq_at_commit);
    @(negedge clk_bus);
    dev_a0 = a0; dev_data_i = d; dev_cs_n = 1'b0; dev_we_n = 1'b0;
    repeat (4) @(negedge clk_bus);
    dev_we_n = 1'b1; dev_cs_n = 1'b1;
    repeat (2) @(negedge clk_bus);
    if (irq_at_commit) loc_irq_set = 16'h0001;
    @(negedge clk_bus);
    loc_irq_set = 16'h0000;
    @(negedge clk_bus);
  endtask

  task automatic bus_read(input logic a0, output logic [15:0] d);
    @(negedge clk_bus);
    dev_a0 = a0; dev_cs_n = 1'b0; dev_rd_n = 1'b0;
    repeat (4) @(negedge clk_bus);
    d = dev_data_o;
    check_eq("t_in_read", {31'd0, dev_data_t}, 32'd0);
    dev_rd_n = 1'b1; dev_cs_n = 1'b1;
    repeat (4) @(negedge clk_bus);
    check_eq("t_after_read", {31'd0, dev_data_t}, 32'd1);
  endtask

  initial begin
    rst_n = 1'b0; dev_a0 = 1'b0; dev_cs_n = 1'b1; dev_rd_n = 1'b1; dev_we_n = 1'b1;
    dev_data_i = 16'h0000; loc_irq_set = 16'h0000;
    repeat (3) @(negedge clk_bus);
    check_eq("rst_data_o", {16'd0, dev_data_o}, 32'h0);
    check_eq("rst_data_t", {31'd0, dev_data_t}, 32'd1);
    check_eq("rst_int", {31'd0, dev_int}, 32'd0);
    check_eq("rst_pulse", {31'd0, loc_wr_pulse}, 32'd0);
    check_eq("rst_index", {25'd0, loc_wr_index}, 32'd0);
    rst_n = 1'b1;
    repeat (2) @(negedge clk_bus);

    bus_read(1'b0, rdat);
    check_eq("rd_no_cmd", {16'd0, rdat}, 32'h0000_FFFF);

    bus_write(1'b1, 16'h0000, 1'b0);
    bus_read(1'b0, rdat);
    check_eq("chip_lo", {16'd0, rdat}, 32'h0000_1362);
    bus_read(1'b0, rdat);
    check_eq("chip_hi", {16'd0, rdat}, 32'h0000_0036);

    p0 = pulse_cnt;
    bus_write(1'b1, 16'h0083, 1'b0);
    bus_write(1'b0, 16'hBEEF, 1'b0);
    check_eq("no_pulse_lo", pulse_cnt - p0, 32'd0);
    bus_write(1'b0, 16'hDEAD, 1'b0);
    check_eq("pulse_cnt3", pulse_cnt - p0, 32'd1);
    check_eq("pulse_idx3", {25'd0, pulse_idx}, 32'd3);
    bus_write(1'b1, 16'h0003, 1'b0);
    bus_read(1'b0, rdat);
    check_eq("r3_lo", {16'd0, rdat}, 32'h0000_BEEF);
    bus_read(1'b0, rdat);
    check_eq("r3_hi", {16'd0, rdat}, 32'h0000_DEAD);
    bus_read(1'b0, rdat);
    check_eq("r3_wrap", {16'd0, rdat}, 32'h0000_BEEF);
    bus_read(1'b1, rdat);
    check_eq("cmd_rd", {16'd0, rdat}, 32'h0000_0003);

    // Register 0 is read-only
    p0 = pulse_cnt;
    bus_write(1'b1, 16'h0080, 1'b0);
    bus_write(1'b0, 16'h1111, 1'b0);
    bus_write(1'b0, 16'h2222, 1'b0);
    check_eq("ro_no_pulse", pulse_cnt - p0, 32'd0);
    bus_write(1'b1, 16'h0000, 1'b0);
    bus_read(1'b0, rdat);
    check_eq("ro_kept", {16'd0, rdat}, 32'h0000_1362);

    // Interrupt path
    bus_write(1'b1, 16'h0082, 1'b0);
    bus_write(1'b0, 16'h0001, 1'b0);
    bus_write(1'b0, 16'h0000, 1'b0);
    check_eq("en_pulse_idx", {25'd0, pulse_idx}, 32'd2);
    check_eq("int_idle", {31'd0, dev_int}, 32'd0);
    @(negedge clk_bus); loc_irq_set = 16'h0001;
    @(negedge clk_bus); loc_irq_set = 16'h0000;
    repeat (2) @(negedge clk_bus);
    check_eq("int_set", {31'd0, dev_int}, 32'd1);
    bus_write(1'b1, 16'h0081, 1'b0);
    bus_write(1'b0, 16'h0001, 1'b0);
    bus_write(1'b0, 16'h0000, 1'b0);
    check_eq("int_w1c", {31'd0, dev_int}, 32'd0);
    @(negedge clk_bus); loc_irq_set = 16'h0001;
    @(negedge clk_bus); loc_irq_set = 16'h0000;
    repeat (2) @(negedge clk_bus);
    check_eq("int_set2", {31'd0, dev_int}, 32'd1);
    bus_write(1'b0, 16'h0001, 1'b0);
    bus_write(1'b0, 16'h0000, 1'b1);
    repeat (2) @(negedge clk_bus);
    check_eq("int_set_wins", {31'd0, dev_int}, 32'd1);
    bus_write(1'b1, 16'h0001, 1'b0);
    bus_read(1'b0, rdat);
    check_eq("status_rd", {16'd0, rdat}, 32'h0000_0001);

    // Unmapped index with NUM_REGS=4
    p0 = pulse_cnt;
    bus_write(1'b1, 16'h0085, 1'b0);
    bus_write(1'b0, 16'h1234, 1'b0);
    bus_write(1'b0, 16'h5678, 1'b0);
    check_eq("unmap_no_pulse", pulse_cnt - p0, 32'd0);
    bus_write(1'b1, 16'h0005, 1'b0);
    bus_read(1'b0, rdat);
    check_eq("unmap_rd", {16'd0, rdat}, 32'h0000_FFFF);

    // Reset in the middle of a read strobe
    bus_write(1'b1, 16'h0003, 1'b0);
    @(negedge clk_bus);
    dev_a0 = 1'b0; dev_cs_n = 1'b0; dev_rd_n = 1'b0;
    repeat (4) @(negedge clk_bus);
    check_eq("mid_rd_t", {31'd0, dev_data_t}, 32'd0);
    check_eq("mid_rd_data", {16'd0, dev_data_o}, 32'h0000_BEEF);
    rst_n = 1'b0;
    @(negedge clk_bus);
    check_eq("rst_mid_t", {31'd0, dev_data_t}, 32'd1);
    check_eq("rst_mid_data", {16'd0, dev_data_o}, 32'h0);
    dev_rd_n = 1'b1; dev_cs_n = 1'b1;
    repeat (3) @(negedge clk_bus);
    rst_n = 1'b1;
    repeat (2) @(negedge clk_bus);
    bus_read(1'b0, rdat);
    check_eq("post_rst_nocmd", {16'd0, rdat}, 32'h0000_FFFF);
    bus_write(1'b1, 16'h0003, 1'b0);
    bus_read(1'b0, rdat);
    check_eq("post_rst_scratch", {16'd0, rdat}, 32'h0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
